// File: rtl/mc_defs.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funct codes,
// FSM states, datapath select codes and the decoded instruction-class vector.
package mc_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_RS     = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  typedef struct packed {
    logic rtype_add;
    logic rtype_sub;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func decoder producing a one-hot instruction class.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  output instr_class_t cls
);

  logic is_r;

  always_comb begin
    is_r          = (op == OP_RTYPE);
    cls           = '0;
    cls.rtype_add = is_r && (func == FN_ADDU);
    cls.rtype_sub = is_r && (func == FN_SUBU);
    cls.jr        = is_r && (func == FN_JR);
    cls.nop       = is_r && (func == FN_NOP);
    cls.ori       = (op == OP_ORI);
    cls.lui       = (op == OP_LUI);
    cls.lw        = (op == OP_LW);
    cls.sw        = (op == OP_SW);
    cls.beq       = (op == OP_BEQ);
    cls.j         = (op == OP_J);
    cls.jal       = (op == OP_JAL);
    // Anything not recognised above is the illegal class, keeping the vector one-hot.
    cls.illegal   = ~(cls.rtype_add | cls.rtype_sub | cls.jr | cls.nop | cls.ori |
                      cls.lui | cls.lw | cls.sw | cls.beq | cls.j | cls.jal);
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives all datapath selects and enables, counts retired instructions.
module mc_controller
  import mc_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       NPCSel,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic             ALUSrc,
  output logic             ExtOp,
  output logic [2:0]       ALUCtrl,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       MemToReg,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d, func_q, func_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  instr_class_t     cls;

  logic       ir_write_c, pc_write_c, reg_write_c, alu_src_c, ext_op_c;
  logic       mem_read_c, mem_write_c, illegal_c, alu_stage;
  logic [1:0] npc_sel_c, reg_dst_c, mem_to_reg_c;
  logic [2:0] alu_ctrl_c;

  // The decoder sees the live IR fields in DECODE and the captured copy afterwards.
  always_comb begin
    op_d   = op_q;
    func_d = func_q;
    if (state_q == S_DECODE) begin
      op_d   = op;
      func_d = func;
    end
  end

  mc_decode u_decode (
    .op   (op_d),
    .func (func_d),
    .cls  (cls)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (cls.rtype_add | cls.rtype_sub | cls.ori | cls.lui | cls.lw | cls.sw)
          state_d = S_EXE;
        else if (cls.beq)
          state_d = S_BRANCH;
        else if (cls.j | cls.jal | cls.jr | cls.nop | cls.illegal)
          state_d = S_JUMP;
        else
          state_d = S_FETCH;
      end
      S_EXE: begin
        if (cls.lw)      state_d = S_MEM_RD;
        else if (cls.sw) state_d = S_MEM_WR;
        else             state_d = S_WB_ALU;
      end
      S_MEM_RD: state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_d = mem_ready ? S_FETCH  : S_MEM_WR;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    npc_sel_c    = NPC_PC4;
    reg_write_c  = 1'b0;
    reg_dst_c    = DST_RT;
    alu_src_c    = 1'b0;
    ext_op_c     = 1'b0;
    alu_ctrl_c   = ALU_ADD;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = WD_ALU;
    illegal_c    = 1'b0;

    // ALU setup from EXE stays put until writeback so address and result are stable.
    alu_stage = (state_q == S_EXE) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR) ||
                (state_q == S_WB_ALU) || (state_q == S_WB_MEM);
    if (alu_stage) begin
      if (cls.rtype_sub)  alu_ctrl_c = ALU_SUB;
      else if (cls.ori)   alu_ctrl_c = ALU_OR;
      else if (cls.lui)   alu_ctrl_c = ALU_LUI;
      else                alu_ctrl_c = ALU_ADD;
      alu_src_c = cls.ori | cls.lui | cls.lw | cls.sw;
      ext_op_c  = cls.lw | cls.sw;
    end

    case (state_q)
      S_FETCH:  ir_write_c = 1'b1;
      S_DECODE: illegal_c  = cls.illegal;
      S_MEM_RD: mem_read_c = 1'b1;
      S_MEM_WR: begin
        mem_write_c = 1'b1;
        pc_write_c  = mem_ready;
      end
      S_WB_ALU: begin
        reg_write_c = 1'b1;
        reg_dst_c   = (cls.rtype_add | cls.rtype_sub) ? DST_RD : DST_RT;
        pc_write_c  = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = WD_MEM;
        pc_write_c   = 1'b1;
      end
      S_BRANCH: begin
        alu_ctrl_c = ALU_SUB;
        pc_write_c = 1'b1;
        npc_sel_c  = Zero ? NPC_BRANCH : NPC_PC4;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        if (cls.j | cls.jal) npc_sel_c = NPC_JUMP;
        else if (cls.jr)     npc_sel_c = NPC_RS;
        if (cls.jal) begin
          reg_write_c  = 1'b1;
          reg_dst_c    = DST_RA;
          mem_to_reg_c = WD_PC4;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pc_write_c};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      func_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset must silence every strobe at once, even though state_q already reads FETCH.
  assign IRWrite   = reset & ir_write_c;
  assign PCWrite   = reset & pc_write_c;
  assign NPCSel    = reset ? npc_sel_c : 2'b00;
  assign RegWrite  = reset & reg_write_c;
  assign RegDst    = reset ? reg_dst_c : 2'b00;
  assign ALUSrc    = reset & alu_src_c;
  assign ExtOp     = reset & ext_op_c;
  assign ALUCtrl   = reset ? alu_ctrl_c : 3'b000;
  assign MemRead   = reset & mem_read_c;
  assign MemWrite  = reset & mem_write_c;
  assign MemToReg  = reset ? mem_to_reg_c : 2'b00;
  assign illegal   = reset & illegal_c;
  assign instr_cnt = cnt_q;
  assign state     = state_q;

endmodule
